rshifter_32bit_seq: RTL and testbench

Sequential 32-bit right shifter: the right-direction counterpart to the ALU logic unit's 32-bit left shifter. It accepts an operand, a shift amount and a logical/arithmetic select on a start pulse. It shifts STEP bit positions per clock until the amount is consumed, then pulses done with the result held stable. It sits in ALU/Logic beside the left shifter and is driven by the ALU control sequencer.

---
 rtl/shifter_pkg.sv | 19 +
 rtl/rshift_step.sv | 28 ++
 rtl/rshifter_32bit_seq.sv | 85 ++++++++
 tb/tb_rshifter_32bit_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the ALU logic-unit shifters: the left shifter's width
// constants and the sequential right shifter's FSM states.
package shifter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  // Per-step shift amount width; STEP is at most 8, so k fits in 0..8.
  localparam int K_W    = 4;

  localparam int LSH_DATA_W = 32;
  localparam int LSH_AMT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rshift_step.sv
// Combinational right shift by k (0..8) positions, vacated top bits taken from
// the fill input. Kept standalone so a rotate unit can reuse it.
module rshift_step
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] i_value,
  input  logic [K_W-1:0]    i_k,
  input  logic              i_fill,
  output logic [DATA_W-1:0] o_value
);

  logic [5:0] w_idx;

  // Output bit i comes from input bit i+k, or from fill once that runs off the top.
  always_comb begin
    o_value = '0;
    w_idx   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_idx = 6'(i) + {2'b00, i_k};
      if (w_idx < 6'(DATA_W)) begin
        o_value[i] = i_value[w_idx[4:0]];
      end else begin
        o_value[i] = i_fill;
      end
    end
  end

endmodule

// File: rtl/rshifter_32bit_seq.sv
// Sequential 32-bit logical/arithmetic right shifter: shifts up to STEP bits per
// clock after an accepted start, then pulses done with the result held on S.
module rshifter_32bit_seq
  import shifter_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] D,
  input  logic [AMT_W-1:0]  amt,
  input  logic              arith,
  output logic [DATA_W-1:0] S,
  output logic              busy,
  output logic              done
);

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_t              r_state;
  state_t              w_nextState;
  logic [AMT_W-1:0]    r_count;
  logic                r_fill;
  logic [DATA_W-1:0]   r_shiftReg;
  logic                w_accept;
  logic [K_W-1:0]      w_k;
  logic [DATA_W-1:0]   w_shifted;

  // Final step may be partial: never shift past the remaining count.
  always_comb begin
    w_k = STEP_AMT[K_W-1:0];
    if (r_count < STEP_AMT) begin
      w_k = r_count[K_W-1:0];
    end
  end

  rshift_step u_step (
    .i_value (r_shiftReg),
    .i_k     (w_k),
    .i_fill  (r_fill),
    .o_value (w_shifted)
  );

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:    w_accept = start;
      SHIFT:   if (r_count == {1'b0, w_k}) w_nextState = DONE;
      DONE: begin
        w_accept    = start;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (w_accept) begin
      w_nextState = (amt != '0) ? SHIFT : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_count    <= '0;
      r_fill     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_shiftReg <= D;
        r_count    <= amt;
        r_fill     <= arith & D[DATA_W-1];
      end else if (r_state == SHIFT) begin
        r_shiftReg <= w_shifted;
        r_count    <= r_count - {1'b0, w_k};
      end
    end
  end

  assign S    = r_shiftReg;
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_rshifter_32bit_seq.sv
// Directed bench for rshifter_32bit_seq, with one STEP=1 and one STEP=4 instance
// sharing operand inputs but driven by separate start strobes.
module tb_rshifter_32bit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [31:0] D;
  logic [4:0]  amt;
  logic        arith;
  logic [31:0] s1, s4;
  logic        busy1, busy4, done1, done4;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  rshifter_32bit_seq #(.STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .D(D), .amt(amt), .arith(arith),
    .S(s1), .busy(busy1), .done(done1)
  );

  rshifter_32bit_seq #(.STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .D(D), .amt(amt), .arith(arith),
    .S(s4), .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit sel, output logic [31:0] s, output logic b, output logic d);
    s = sel ? s4 : s1;
    b = sel ? busy4 : busy1;
    d = sel ? done4 : done1;
  endtask

  // Accepts one operation, then observes the cycles after the accepting edge
  // (index 0 = cycle after accept) until one cycle past the first done.
  task automatic runOp(input bit sel, input logic [31:0] d, input logic [4:0] a,
                       input logic ar, output logic [31:0] res, output int busyCnt,
                       output int doneCnt, output int doneAt);
    logic [31:0] s;
    logic b, dn;
    D = d; amt = a; arith = ar;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    busyCnt = 0; doneCnt = 0; doneAt = -1; res = '0;
    for (int j = 0; j < 60; j++) begin
      sample(sel, s, b, dn);
      if (b) busyCnt++;
      if (dn) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = j;
          res = s;
        end
      end
      if (doneAt >= 0 && j > doneAt) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    D = 32'hDEADBEEF; amt = 5'd7; arith = 1'b1;
    tick(); tick();
    nChecks++; if (s1 !== 32'h0) begin nFails++; $display("[TB] FAIL reset_s1 got %h want %h", s1, 32'h0); end
    nChecks++; if (s4 !== 32'h0) begin nFails++; $display("[TB] FAIL reset_s4 got %h want %h", s4, 32'h0); end
    nChecks++; if ({busy1, done1, busy4, done4} !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_flags got %b want 0000", {busy1, done1, busy4, done4}); end
    reset = 1'b0;
    tick();
    nChecks++; if ({busy1, done1} !== 2'b00 || s1 !== 32'h0) begin nFails++; $display("[TB] FAIL idle_after_reset got %b/%h want 00/0", {busy1, done1}, s1); end
  endtask

  task automatic test_logical_step1();
    logic [31:0] r; int bc, dc, da;
    runOp(1'b0, 32'h96969696, 5'd1, 1'b0, r, bc, dc, da);
    nChecks++; if (r !== 32'h4B4B4B4B) begin nFails++; $display("[TB] FAIL lsr1_result got %h want %h", r, 32'h4B4B4B4B); end
    nChecks++; if (bc !== 1) begin nFails++; $display("[TB] FAIL lsr1_busy got %0d want 1", bc); end
    nChecks++; if (da !== 1) begin nFails++; $display("[TB] FAIL lsr1_done_at got %0d want 1", da); end
    nChecks++; if (dc !== 1) begin nFails++; $display("[TB] FAIL lsr1_done_width got %0d want 1", dc); end
  endtask

  task automatic test_arith_step1();
    logic [31:0] r; int bc, dc, da;
    runOp(1'b0, 32'hE6E6E6E6, 5'd4, 1'b1, r, bc, dc, da);
    nChecks++; if (r !== 32'hFE6E6E6E) begin nFails++; $display("[TB] FAIL asr4_result got %h want %h", r, 32'hFE6E6E6E); end
    nChecks++; if (bc !== 4) begin nFails++; $display("[TB] FAIL asr4_busy got %0d want 4", bc); end
    nChecks++; if (da !== 4) begin nFails++; $display("[TB] FAIL asr4_done_at got %0d want 4", da); end
    nChecks++; if (dc !== 1) begin nFails++; $display("[TB] FAIL asr4_done_width got %0d want 1", dc); end
  endtask

  task automatic test_step4_partial();
    logic [31:0] r; int bc, dc, da;
    runOp(1'b1, 32'h80000000, 5'd31, 1'b1, r, bc, dc, da);
    nChecks++; if (r !== 32'hFFFFFFFF) begin nFails++; $display("[TB] FAIL s4_asr31_result got %h want %h", r, 32'hFFFFFFFF); end
    nChecks++; if (bc !== 8) begin nFails++; $display("[TB] FAIL s4_asr31_busy got %0d want 8", bc); end
    nChecks++; if (da !== 8) begin nFails++; $display("[TB] FAIL s4_asr31_done_at got %0d want 8", da); end
    runOp(1'b1, 32'h80000000, 5'd31, 1'b0, r, bc, dc, da);
    nChecks++; if (r !== 32'h00000001) begin nFails++; $display("[TB] FAIL s4_lsr31_result got %h want %h", r, 32'h1); end
    nChecks++; if (dc !== 1 || da !== 8) begin nFails++; $display("[TB] FAIL s4_lsr31_timing got done_at %0d width %0d want 8/1", da, dc); end
    runOp(1'b1, 32'h12345678, 5'd6, 1'b1, r, bc, dc, da);
    nChecks++; if (r !== 32'h0048D159 || da !== 2) begin nFails++; $display("[TB] FAIL s4_asr6 got %h at %0d want 0048d159 at 2", r, da); end
  endtask

  task automatic test_zero_amt();
    logic [31:0] r; int bc, dc, da;
    runOp(1'b0, 32'h3A3A3A3A, 5'd0, 1'b1, r, bc, dc, da);
    nChecks++; if (r !== 32'h3A3A3A3A) begin nFails++; $display("[TB] FAIL amt0_result got %h want %h", r, 32'h3A3A3A3A); end
    nChecks++; if (da !== 0) begin nFails++; $display("[TB] FAIL amt0_done_at got %0d want 0", da); end
    nChecks++; if (bc !== 0) begin nFails++; $display("[TB] FAIL amt0_busy got %0d want 0", bc); end
    D = 32'h11111111;
    tick(); tick(); tick();
    nChecks++; if (s1 !== 32'h3A3A3A3A || done1 !== 1'b0) begin nFails++; $display("[TB] FAIL idle_hold got %h/%b want 3a3a3a3a/0", s1, done1); end
  endtask

  task automatic test_back_to_back();
    D = 32'h32323232; amt = 5'd2; arith = 1'b0; start1 = 1'b1;
    tick();
    D = 32'hFFFFFFFF; amt = 5'd1; arith = 1'b0;
    nChecks++; if (busy1 !== 1'b1 || s1 !== 32'h32323232) begin nFails++; $display("[TB] FAIL b2b_j0 got %b/%h want 1/32323232", busy1, s1); end
    tick();
    nChecks++; if (busy1 !== 1'b1 || s1 !== 32'h19191919) begin nFails++; $display("[TB] FAIL b2b_j1 got %b/%h want 1/19191919", busy1, s1); end
    tick();
    nChecks++; if (done1 !== 1'b1 || s1 !== 32'h0C8C8C8C) begin nFails++; $display("[TB] FAIL b2b_first got %b/%h want 1/0c8c8c8c", done1, s1); end
    tick();
    nChecks++; if ({busy1, done1} !== 2'b10 || s1 !== 32'hFFFFFFFF) begin nFails++; $display("[TB] FAIL b2b_second_accept got %b/%h want 10/ffffffff", {busy1, done1}, s1); end
    start1 = 1'b0;
    tick();
    nChecks++; if (done1 !== 1'b1 || s1 !== 32'h7FFFFFFF) begin nFails++; $display("[TB] FAIL b2b_second got %b/%h want 1/7fffffff", done1, s1); end
    tick();
    nChecks++; if ({busy1, done1} !== 2'b00) begin nFails++; $display("[TB] FAIL b2b_idle got %b want 00", {busy1, done1}); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r; int bc, dc, da; int sawDone;
    D = 32'hF0000000; amt = 5'd20; arith = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    nChecks++; if (busy1 !== 1'b1 || s1 !== 32'h07800000) begin nFails++; $display("[TB] FAIL mid_shift got %b/%h want 1/07800000", busy1, s1); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++; if ({busy1, done1} !== 2'b00 || s1 !== 32'h0) begin nFails++; $display("[TB] FAIL abort got %b/%h want 00/0", {busy1, done1}, s1); end
    sawDone = 0;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (done1 || busy1) sawDone++;
    end
    nChecks++; if (sawDone !== 0) begin nFails++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", sawDone); end
    runOp(1'b0, 32'hA5A5A5A5, 5'd3, 1'b1, r, bc, dc, da);
    nChecks++; if (r !== 32'hF4B4B4B4 || da !== 3) begin nFails++; $display("[TB] FAIL post_abort got %h at %0d want f4b4b4b4 at 3", r, da); end
  endtask

  initial begin
    test_reset();
    test_logical_step1();
    test_arith_step1();
    test_step4_partial();
    test_zero_amt();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
